mem_latency_ctrl: RTL

MEM_LATENCY_CTRL -- requirements
Module: mem_latency_ctrl

---
 rtl/mem_latency_ctrl_pkg.sv | 21 ++
 rtl/mem_latency_ctrl_rr_arbiter.sv | 33 +++
 rtl/mem_latency_ctrl.sv | 130 +++++++++++++
 3 files changed

// File: rtl/mem_latency_ctrl_pkg.sv
// Shared types and constants for the memory latency controller.
package mem_lat_pkg;

    // Width of the latency down-counter (latencies up to 255).
    localparam int LAT_W = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_e;

    // Ceiling log2, usable in constant expressions.
    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction

endpackage

// File: rtl/mem_latency_ctrl_rr_arbiter.sv
// Round-robin arbiter: searches req starting at rr_ptr, returns the first hit.
module rr_arbiter
    import mem_lat_pkg::*;
#(
    parameter int NUM_CH = 2,
    parameter int IDX_W  = 1
) (
    input  logic [NUM_CH-1:0] req,
    input  logic [IDX_W-1:0]  rr_ptr,
    output logic [NUM_CH-1:0] grant,
    output logic [IDX_W-1:0]  idx
);

    logic [IDX_W-1:0] cidx;
    logic             found;

    // Walk the channels in rotated order; the first requester wins.
    always_comb begin
        grant = '0;
        idx   = '0;
        cidx  = '0;
        found = 1'b0;
        for (int k = 0; k < NUM_CH; k++) begin
            cidx = IDX_W'((int'(rr_ptr) + k) % NUM_CH);
            if (!found && req[cidx]) begin
                found       = 1'b1;
                grant[cidx] = 1'b1;
                idx         = cidx;
            end
        end
    end

endmodule

// File: rtl/mem_latency_ctrl.sv
// Fixed-latency memory access controller: arbitrates channels, stalls the
// requester for the configured read/write latency, pulses done at the end.
module mem_latency_ctrl
    import mem_lat_pkg::*;
#(
    parameter  int NUM_CH = 2,
    parameter  int RD_LAT = 8,
    parameter  int WR_LAT = 8,
    localparam int IDX_W  = (NUM_CH > 1) ? clog2(NUM_CH) : 1
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic [NUM_CH-1:0] req,
    input  logic [NUM_CH-1:0] we,
    output logic [NUM_CH-1:0] stall,
    output logic [NUM_CH-1:0] done,
    output logic              mem_cmd,
    output logic              mem_we,
    output logic [IDX_W-1:0]  gnt_ch,
    output logic              busy,
    output logic [31:0]       stall_cycles
);

    // Reject illegal configurations at elaboration.
    if (NUM_CH < 1) begin : g_bad_ch
        $error("mem_latency_ctrl: NUM_CH must be >= 1");
    end
    if (RD_LAT < 2 || RD_LAT > 255) begin : g_bad_rd
        $error("mem_latency_ctrl: RD_LAT must be in 2..255");
    end
    if (WR_LAT < 2 || WR_LAT > 255) begin : g_bad_wr
        $error("mem_latency_ctrl: WR_LAT must be in 2..255");
    end

    state_e            state_q, state_d;
    logic [LAT_W-1:0]  cnt_q, cnt_d;
    logic [IDX_W-1:0]  rr_ptr_q, rr_ptr_d;
    logic [IDX_W-1:0]  gnt_q, gnt_d;
    logic              we_q, we_d;
    logic              cmd_q, cmd_d;
    logic [31:0]       stall_cycles_q, stall_cycles_d;

    logic [NUM_CH-1:0] arb_grant;
    logic [IDX_W-1:0]  arb_idx;

    rr_arbiter #(
        .NUM_CH (NUM_CH),
        .IDX_W  (IDX_W)
    ) u_arb (
        .req    (req),
        .rr_ptr (rr_ptr_q),
        .grant  (arb_grant),
        .idx    (arb_idx)
    );

    // Next-state logic. The arbitration happens in IDLE; the first ACCESS
    // cycle is access cycle 1, so loading L-2 and leaving ACCESS when the
    // counter reads 0 lands DONE exactly on cycle L.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        rr_ptr_d = rr_ptr_q;
        gnt_d    = gnt_q;
        we_d     = we_q;
        cmd_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (|req) begin
                    state_d  = ACCESS;
                    gnt_d    = arb_idx;
                    we_d     = we[arb_idx];
                    cnt_d    = we[arb_idx] ? LAT_W'(WR_LAT - 2) : LAT_W'(RD_LAT - 2);
                    rr_ptr_d = (int'(arb_idx) == NUM_CH - 1) ? '0 : arb_idx + IDX_W'(1);
                    cmd_d    = 1'b1;
                end
            end
            ACCESS: begin
                if (cnt_q == '0) state_d = DONE;
                else             cnt_d   = cnt_q - LAT_W'(1);
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Saturating count of cycles in which any channel is stalled.
    always_comb begin
        stall_cycles_d = stall_cycles_q;
        if (|stall && stall_cycles_q != 32'hFFFF_FFFF)
            stall_cycles_d = stall_cycles_q + 32'd1;
    end

    // State registers; reset overrides everything, aborting any access.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q        <= IDLE;
            cnt_q          <= '0;
            rr_ptr_q       <= '0;
            gnt_q          <= '0;
            we_q           <= 1'b0;
            cmd_q          <= 1'b0;
            stall_cycles_q <= '0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            rr_ptr_q       <= rr_ptr_d;
            gnt_q          <= gnt_d;
            we_q           <= we_d;
            cmd_q          <= cmd_d;
            stall_cycles_q <= stall_cycles_d;
        end
    end

    // Done pulse for the owning channel; masked while reset is asserted so a
    // reset landing on the DONE cycle still yields no completion.
    always_comb begin
        done = '0;
        for (int i = 0; i < NUM_CH; i++)
            done[i] = (state_q == DONE) && (gnt_q == IDX_W'(i)) && !RST;
    end

    // Any requester stalls unless it is completing this cycle.
    assign stall        = req & ~done;
    assign mem_cmd      = cmd_q & ~RST;
    assign busy         = (state_q != IDLE) & ~RST;
    assign mem_we       = we_q;
    assign gnt_ch       = gnt_q;
    assign stall_cycles = stall_cycles_q;

endmodule
